// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
//   Time-multiplexed scan controller for NUM_DIGITS common-anode 7-segment
//   digits sharing one hex decoder. Each digit owns a DWELL-cycle slot whose
//   first BLANK_CYCLES cycles keep every anode off to stop ghosting. Displayed
//   data is double-buffered: loads land in a staging register and are moved
//   into the shadow register only at a frame boundary (or while idle), so a
//   frame is never torn between old and new values.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   en         in   scan enable; 0 = display dark, counters parked
//   load       in   1-cycle strobe: capture value_in/dp_in into staging
//   value_in   in   [4*NUM_DIGITS] nibble k = digit k (digit 0 = LSD)
//   dp_in      in   [NUM_DIGITS]   bit k = decimal point of digit k (1 = lit)
//   lz_en      in   leading-zero suppression enable (live)
//   bcd        out  [4]            nibble of the current digit, to decoder
//   an_n       out  [NUM_DIGITS]   active-low one-hot anode select
//   dp_n       out  active-low decimal point
//   frame_done out  1-cycle pulse, coincident with the first blank slot of
//                   a new frame
//   pending    out  staged data waiting for a frame boundary
// -----------------------------------------------------------------------------
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL        = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lz_en,
    output logic [3:0]              bcd,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    dp_n,
    output logic                    frame_done,
    output logic                    pending
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(DWELL);

    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        SHOW
    } state_t;

    state_t                           st, st_next;
    logic [IDX_W-1:0]                 idx, idx_next;
    logic [CNT_W-1:0]                 cnt, cnt_next;
    logic                             wrap;

    logic [NUM_DIGITS-1:0][3:0]       shadow, staged;
    logic [NUM_DIGITS-1:0]            dp_shadow, dp_staged;
    logic [NUM_DIGITS-1:0]            sup;
    logic                             lead_zero;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            st         <= IDLE;
            idx        <= '0;
            cnt        <= '0;
            frame_done <= 1'b0;
        end else begin
            st         <= st_next;
            idx        <= idx_next;
            cnt        <= cnt_next;
            frame_done <= wrap;
        end
    end

    // Next-state: the BLANK/SHOW split is derived from the next count so that
    // st always agrees with cnt in the same cycle.
    always_comb begin
        st_next  = st;
        idx_next = idx;
        cnt_next = cnt;
        wrap     = 1'b0;
        if (!en) begin
            st_next  = IDLE;
            idx_next = '0;
            cnt_next = '0;
        end else if (st == IDLE) begin
            st_next  = BLANK;
            idx_next = '0;
            cnt_next = '0;
        end else begin
            if (cnt == CNT_LAST) begin
                cnt_next = '0;
                if (idx == IDX_LAST) begin
                    idx_next = '0;
                    wrap     = 1'b1;
                end else begin
                    idx_next = idx + 1'b1;
                end
            end else begin
                cnt_next = cnt + 1'b1;
            end
            st_next = (cnt_next < CNT_BLANK) ? BLANK : SHOW;
        end
    end

    // Staging / shadow buffers. A load on the wrap edge bypasses staging so
    // the new value is visible from digit 0 of the frame that is starting.
    always_ff @(posedge clk) begin
        if (rst) begin
            staged    <= '0;
            dp_staged <= '0;
            shadow    <= '0;
            dp_shadow <= '0;
            pending   <= 1'b0;
        end else begin
            if (load) begin
                staged    <= value_in;
                dp_staged <= dp_in;
            end
            if (wrap && load) begin
                shadow    <= value_in;
                dp_shadow <= dp_in;
                pending   <= 1'b0;
            end else if ((wrap || st == IDLE) && pending) begin
                shadow    <= staged;
                dp_shadow <= dp_staged;
                pending   <= load;
            end else if (load) begin
                pending   <= 1'b1;
            end
        end
    end

    // Leading-zero map: digit k (k > 0) is suppressed when every nibble from
    // the MSD down to k is zero. Digit 0 is never suppressed.
    always_comb begin
        lead_zero = lz_en;
        sup       = '0;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            lead_zero = lead_zero & (shadow[k] == 4'h0);
            sup[k]    = lead_zero;
        end
    end

    // Moore output decode
    always_comb begin
        bcd  = shadow[idx];
        an_n = '1;
        dp_n = 1'b1;
        if (st == SHOW && !sup[idx]) begin
            an_n[idx] = 1'b0;
            dp_n      = ~dp_shadow[idx];
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;

    localparam int ND = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        load;
    logic [15:0] value_in;
    logic [3:0]  dp_in;
    logic        lz_en;
    logic [3:0]  bcd;
    logic [3:0]  an_n;
    logic        dp_n;
    logic        frame_done;
    logic        pending;

    int checks   = 0;
    int failures = 0;
    int pos      = 0;

    seg_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .DWELL       (8),
        .BLANK_CYCLES(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .load      (load),
        .value_in  (value_in),
        .dp_in     (dp_in),
        .lz_en     (lz_en),
        .bcd       (bcd),
        .an_n      (an_n),
        .dp_n      (dp_n),
        .frame_done(frame_done),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (pos %0d)", tag, got, exp, pos);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        pos++;
    endtask

    task automatic run_to(input int target);
        while (pos < target) tick();
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        value_in = v;
        dp_in    = d;
        load     = 1'b1;
        tick();
        load     = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; load = 1'b1; value_in = 16'hFFFF; dp_in = 4'hF; lz_en = 1'b0;

        // 1: reset held with en/load active
        repeat (3) tick();
        chk("rst_an", an_n, 4'b1111);
        chk("rst_dp", dp_n, 1'b1);
        chk("rst_bcd", bcd, 4'h0);
        chk("rst_pend", pending, 1'b0);
        chk("rst_fd", frame_done, 1'b0);

        rst = 1'b0; en = 1'b0; load = 1'b0;
        tick();
        chk("idle_an", an_n, 4'b1111);

        // 2: start scanning and load 12AF in the same cycle
        en = 1'b1;
        do_load(16'h12AF, 4'b0100);
        pos = 0;
        chk("start_pend", pending, 1'b1);
        chk("start_blank_an", an_n, 4'b1111);
        run_to(2);
        chk("f0_idx0_an", an_n, 4'b1110);
        chk("f0_idx0_bcd", bcd, 4'h0);
        run_to(31);
        chk("pre_wrap_pend", pending, 1'b1);
        chk("pre_wrap_fd", frame_done, 1'b0);
        run_to(32);
        chk("wrap1_fd", frame_done, 1'b1);
        chk("wrap1_pend", pending, 1'b0);
        chk("wrap1_an", an_n, 4'b1111);
        chk("wrap1_bcd", bcd, 4'hF);
        run_to(33);
        chk("fd_pulse", frame_done, 1'b0);
        run_to(34);
        chk("f1_idx0_an", an_n, 4'b1110);
        chk("f1_idx0_bcd", bcd, 4'hF);
        chk("f1_idx0_dp", dp_n, 1'b1);
        run_to(50);
        chk("f1_idx2_an", an_n, 4'b1011);
        chk("f1_idx2_bcd", bcd, 4'h2);
        chk("f1_idx2_dp", dp_n, 1'b0);
        run_to(63);
        chk("f1_end_fd", frame_done, 1'b0);
        run_to(64);
        chk("wrap2_fd", frame_done, 1'b1);

        // 3: mid-frame load is deferred; wrap-edge load is immediate
        run_to(76);
        do_load(16'h3333, 4'b0000);
        chk("mid_pend", pending, 1'b1);
        run_to(90);
        chk("mid_idx3_an", an_n, 4'b0111);
        chk("mid_idx3_bcd", bcd, 4'h1);
        run_to(96);
        chk("wrap3_fd", frame_done, 1'b1);
        chk("wrap3_bcd", bcd, 4'h3);
        chk("wrap3_pend", pending, 1'b0);
        run_to(127);
        do_load(16'h4567, 4'b0001);
        chk("edge_load_pend", pending, 1'b0);
        chk("edge_load_bcd", bcd, 4'h7);
        chk("edge_load_fd", frame_done, 1'b1);
        run_to(130);
        chk("edge_idx0_an", an_n, 4'b1110);
        chk("edge_idx0_dp", dp_n, 1'b0);

        // 4: leading-zero suppression
        lz_en = 1'b1;
        run_to(159);
        do_load(16'h0005, 4'b0000);
        run_to(162);
        chk("lz5_idx0_an", an_n, 4'b1110);
        chk("lz5_idx0_bcd", bcd, 4'h5);
        run_to(170);
        chk("lz5_idx1_an", an_n, 4'b1111);
        chk("lz5_idx1_bcd", bcd, 4'h0);
        run_to(186);
        chk("lz5_idx3_an", an_n, 4'b1111);
        run_to(191);
        do_load(16'h0000, 4'b0000);
        run_to(194);
        chk("lz0_idx0_an", an_n, 4'b1110);
        chk("lz0_idx0_bcd", bcd, 4'h0);
        run_to(202);
        chk("lz0_idx1_an", an_n, 4'b1111);
        run_to(223);
        do_load(16'h0500, 4'b1000);
        run_to(226);
        chk("lz500_idx0_an", an_n, 4'b1110);
        run_to(234);
        chk("lz500_idx1_an", an_n, 4'b1101);
        chk("lz500_idx1_bcd", bcd, 4'h0);
        run_to(242);
        chk("lz500_idx2_an", an_n, 4'b1011);
        chk("lz500_idx2_bcd", bcd, 4'h5);
        run_to(250);
        chk("lz500_idx3_an", an_n, 4'b1111);
        chk("lz500_idx3_dp", dp_n, 1'b1);
        lz_en = 1'b0;
        #1;
        chk("lz_off_idx3_an", an_n, 4'b0111);
        chk("lz_off_idx3_dp", dp_n, 1'b0);

        // 5: enable drop mid-frame, idle load, restart
        run_to(277);
        en = 1'b0;
        tick();
        chk("en_off_an", an_n, 4'b1111);
        chk("en_off_dp", dp_n, 1'b1);
        chk("en_off_fd", frame_done, 1'b0);
        run_to(290);
        chk("en_off_no_fd", frame_done, 1'b0);
        do_load(16'h9876, 4'b0000);
        chk("idle_load_pend", pending, 1'b1);
        chk("idle_load_bcd_old", bcd, 4'h0);
        tick();
        chk("idle_apply_pend", pending, 1'b0);
        chk("idle_apply_bcd", bcd, 4'h6);
        en = 1'b1;
        tick();
        pos = 0;
        chk("restart_an", an_n, 4'b1111);
        chk("restart_bcd", bcd, 4'h6);
        run_to(2);
        chk("restart_idx0_an", an_n, 4'b1110);
        run_to(10);
        chk("restart_idx1_an", an_n, 4'b1101);
        chk("restart_idx1_bcd", bcd, 4'h7);
        run_to(18);
        chk("restart_idx2_bcd", bcd, 4'h8);

        // 6: reset mid-frame with data pending
        run_to(20);
        do_load(16'hABCD, 4'b1111);
        chk("pre_rst_pend", pending, 1'b1);
        run_to(30);
        chk("pre_rst_an", an_n, 4'b0111);
        rst = 1'b1;
        tick();
        chk("mid_rst_an", an_n, 4'b1111);
        chk("mid_rst_dp", dp_n, 1'b1);
        chk("mid_rst_bcd", bcd, 4'h0);
        chk("mid_rst_pend", pending, 1'b0);
        chk("mid_rst_fd", frame_done, 1'b0);
        rst = 1'b0;
        tick();
        pos = 0;
        run_to(2);
        chk("post_rst_idx0_an", an_n, 4'b1110);
        chk("post_rst_idx0_bcd", bcd, 4'h0);
        run_to(32);
        chk("post_rst_fd", frame_done, 1'b1);
        chk("post_rst_discard_bcd", bcd, 4'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
